encoder_16x4_seq: RTL and testbench

ENCODER_16X4_SEQ -- requirements
Module: encoder_16x4_seq

---
 rtl/encoder_16x4_seq.sv | 60 ++++++
 tb/tb_encoder_16x4_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/encoder_16x4_seq.sv
// encoder_16x4_seq: pending-line encoder with valid/ready handshake; define ENC_ROUND_ROBIN_EN for round-robin arbitration.
module encoder_16x4_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        e,
  input  logic        ready,
  output logic [3:0]  code,
  output logic        valid,
  output logic [15:0] pend,
  output logic        ovf
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [3:0] code_q, code_d, sel, base;
  logic [15:0] pend_q, pend_d, clr;
  logic ovf_q, ovf_d, load;
`ifdef ENC_ROUND_ROBIN_EN
  logic [3:0] ptr_q, ptr_d;
  assign base = ptr_q;
  assign ptr_d = load ? sel + 4'd1 : ptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= 4'd0;
    else ptr_q <= ptr_d;
`else
  assign base = 4'd0;
`endif
  // Descending scan so the candidate nearest the search base is the last one kept.
  always_comb begin
    sel = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (pend_q[base + 4'(i)]) sel = base + 4'(i);
  end
  always_comb begin
    load = e && (pend_q != 16'd0) && (state_q == IDLE || ready);
    clr = load ? 16'd1 << sel : 16'd0;
    pend_d = (pend_q & ~clr) | req;
    ovf_d = |(req & pend_q & ~clr);
    code_d = load ? sel : code_q;
  end
  always_comb state_d = load ? HOLD : (state_q == HOLD && !ready) ? HOLD : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      code_q <= 4'd0;
      pend_q <= 16'd0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
    end
  always_comb begin
    valid = state_q == HOLD;
    code = code_q;
    pend = pend_q;
    ovf = ovf_q;
  end
endmodule

// File: tb/tb_encoder_16x4_seq.sv
// tb_encoder_16x4_seq: directed and randomized checks of encoder_16x4_seq against a transaction-level model.
module tb_encoder_16x4_seq;
  logic clk = 1'b0, rst = 1'b1, e = 1'b0, ready = 1'b0;
  logic [15:0] req = 16'd0;
  logic [3:0] code;
  logic valid, ovf;
  logic [15:0] pend;
  int checks = 0, failures = 0;
  int m_pend, m_code, m_ptr;
  bit m_valid, m_ovf;

  encoder_16x4_seq dut (.clk(clk), .rst(rst), .req(req), .e(e), .ready(ready),
                        .code(code), .valid(valid), .pend(pend), .ovf(ovf));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    int base;
`ifdef ENC_ROUND_ROBIN_EN
    base = m_ptr;
`else
    base = 0;
`endif
    for (int k = 0; k < 16; k++)
      if (m_pend[(base + k) % 16]) return (base + k) % 16;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_code = 0; m_ptr = 0; m_valid = 0; m_ovf = 0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".code"}, int'(code), m_code);
    chk({tag, ".valid"}, int'(valid), int'(m_valid));
    chk({tag, ".pend"}, int'(pend), m_pend);
    chk({tag, ".ovf"}, int'(ovf), int'(m_ovf));
  endtask

  task automatic step(input logic [15:0] r, input logic en, input logic rd, input string tag);
    int g, clrm;
    bit ld;
    req = r; e = en; ready = rd;
    g = pick();
    ld = en && m_pend != 0 && (!m_valid || rd);
    clrm = ld ? (1 << g) : 0;
    @(posedge clk);
    #1;
    m_ovf = (int'(r) & m_pend & ~clrm) != 0;
    m_pend = (m_pend & ~clrm) | int'(r);
    m_valid = ld ? 1'b1 : (m_valid && !rd);
    if (ld) begin
      m_code = g;
      m_ptr = (g + 1) % 16;
    end
    compare_all(tag);
  endtask

  task automatic do_reset();
    req = 16'hFFFF;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 16'd0;
    model_reset();
    compare_all("reset");
  endtask

  initial begin
    model_reset();
    #2;
    compare_all("por");
    do_reset();
    // single pulse latency
    step(16'h0020, 1, 1, "lat0");
    chk("lat0.valid", int'(valid), 0);
    step(16'h0000, 1, 1, "lat1");
    chk("lat1.valid", int'(valid), 1);
    chk("lat1.code", int'(code), 5);
    step(16'h0000, 1, 1, "lat2");
    chk("lat2.valid", int'(valid), 0);
    chk("lat2.pend", int'(pend), 0);
    // two lines, back to back
    do_reset();
    step(16'h8001, 1, 1, "two0");
    step(16'h0000, 1, 1, "two1");
    chk("two1.code", int'(code), 0);
    step(16'h0000, 1, 1, "two2");
    chk("two2.code", int'(code), 15);
    chk("two2.valid", int'(valid), 1);
    step(16'h0000, 1, 1, "two3");
    // arbitration order after granting 1
    do_reset();
    step(16'h0003, 0, 1, "arb0");
    step(16'h0000, 1, 1, "arb1");
    step(16'h8003, 1, 1, "arb2");
    chk("arb2.code", int'(code), 1);
    chk("arb2.pend", int'(pend), 16'h8003);
    step(16'h0000, 1, 1, "arb3");
`ifdef ENC_ROUND_ROBIN_EN
    chk("arb3.code", int'(code), 15);
    step(16'h0000, 1, 1, "arb4");
    chk("arb4.code", int'(code), 0);
`else
    chk("arb3.code", int'(code), 0);
    step(16'h0000, 1, 1, "arb4");
    chk("arb4.code", int'(code), 1);
`endif
    for (int i = 0; i < 3; i++) step(16'h0000, 1, 1, "arbd");
    // hold under backpressure with repeated request
    do_reset();
    step(16'h0008, 1, 0, "bp0");
    step(16'h0008, 1, 0, "bp1");
    chk("bp1.code", int'(code), 3);
    for (int i = 0; i < 5; i++) begin
      step(16'h0008, i[0], 0, "bph");
      chk("bph.code", int'(code), 3);
      chk("bph.ovf", int'(ovf), 1);
      chk("bph.pend", int'(pend), 16'h0008);
    end
    step(16'h0000, 1, 1, "bp2");
    chk("bp2.code", int'(code), 3);
    chk("bp2.valid", int'(valid), 1);
    chk("bp2.ovf", int'(ovf), 0);
    step(16'h0000, 1, 1, "bp3");
    chk("bp3.valid", int'(valid), 0);
    // enable gating then burst
    do_reset();
    step(16'h00F0, 0, 1, "en0");
    step(16'h0000, 0, 1, "en1");
    chk("en1.valid", int'(valid), 0);
    chk("en1.pend", int'(pend), 16'h00F0);
    for (int i = 4; i < 8; i++) begin
      step(16'h0000, 1, 1, "burst");
      chk("burst.code", int'(code), i);
      chk("burst.valid", int'(valid), 1);
    end
    step(16'h0000, 1, 1, "burst_end");
    // asynchronous reset mid-hold
    step(16'hFFFF, 0, 0, "ar0");
    step(16'h0000, 1, 0, "ar1");
    chk("ar1.valid", int'(valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar.valid", int'(valid), 0);
    chk("ar.pend", int'(pend), 0);
    chk("ar.code", int'(code), 0);
    req = 16'hFFFF;
    @(posedge clk);
    #1;
    chk("ar_req.pend", int'(pend), 0);
    rst = 1'b0;
    req = 16'd0;
    model_reset();
    step(16'h0400, 1, 1, "ar2");
    step(16'h0000, 1, 1, "ar3");
    chk("ar3.code", int'(code), 10);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] r;
      r = ($urandom_range(0, 3) == 0) ? 16'($urandom) & 16'($urandom) : 16'd0;
      step(r, $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0, "rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
